// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: write-back source codes,
// reset constants, FSM state encoding and the write-back select helper.
package mem_stage_pkg;

    localparam int WDATA_SRC_LENGTH = 2;

    localparam logic [WDATA_SRC_LENGTH-1:0] WDATA_SRC_ALU = 2'd0;
    localparam logic [WDATA_SRC_LENGTH-1:0] WDATA_SRC_MEM = 2'd1;
    localparam logic [WDATA_SRC_LENGTH-1:0] WDATA_SRC_PC8 = 2'd2;

    localparam logic [31:0] INIT_32 = 32'd0;
    localparam logic [1:0]  INIT_2  = 2'd0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

    // Unused code 3 falls back to the ALU result.
    function automatic logic [31:0] wb_select(
        input logic [WDATA_SRC_LENGTH-1:0] src,
        input logic [31:0]                 alu,
        input logic [31:0]                 rdata,
        input logic [31:0]                 pc8
    );
        case (src)
            WDATA_SRC_MEM: wb_select = rdata;
            WDATA_SRC_PC8: wb_select = pc8;
            default:       wb_select = alu;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register: loads every cycle, or inserts a bubble
// (write enable cleared, address/data held) when the stage is stalled.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble_i,
    input  logic        we_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] data_i,
    output logic        wb_reg_we,
    output logic [4:0]  wb_reg_addr,
    output logic [31:0] wb_data
);

    logic        we_q;
    logic [4:0]  addr_q;
    logic [31:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q   <= 1'b0;
            addr_q <= 5'd0;
            data_q <= INIT_32;
        end else if (bubble_i) begin
            we_q   <= 1'b0;
        end else begin
            we_q   <= we_i;
            addr_q <= addr_i;
            data_q <= data_i;
        end
    end

    assign wb_reg_we   = we_q;
    assign wb_reg_addr = addr_q;
    assign wb_data     = data_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: req/ack data-memory access with upstream stall and
// MEM/WB register. Define MEM_TIMEOUT_EN to add the WAIT-state timeout.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        DataMemWE,
    input  logic [WDATA_SRC_LENGTH-1:0] WriteDataSrc,
    input  logic [31:0]                 ALURes,
    input  logic [31:0]                 Reg2DataOut,
    input  logic [4:0]                  WriteRegSrc,
    input  logic                        RegWE,
    input  logic [31:0]                 PCplus8,
    mem_stage_if.master                 dmem,
    output logic                        stall,
    output logic                        misalign,
    output logic                        wb_reg_we,
    output logic [4:0]                  wb_reg_addr,
    output logic [31:0]                 wb_data
`ifdef MEM_TIMEOUT_EN
    ,
    output logic                        mem_timeout
`endif
);

    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be below 2**CNT_W");
    end

    mem_state_e                  state_q;
    logic                        misalign_q;
    logic                        h_we_q;
    logic [31:0]                 h_addr_q;
    logic [31:0]                 h_wdata_q;
    logic [4:0]                  h_rd_q;
    logic                        h_regwe_q;
    logic [WDATA_SRC_LENGTH-1:0] h_wsrc_q;

    logic memop, aligned, in_wait, issue, bad_access, timeout_hit, req, bubble;
    logic        wb_we_d;
    logic [4:0]  wb_addr_d;
    logic [31:0] wb_data_d;

    assign memop      = DataMemWE | (WriteDataSrc == WDATA_SRC_MEM);
    assign aligned    = (ALURes[1:0] == INIT_2);
    assign in_wait    = (state_q == S_WAIT);
    assign issue      = ~in_wait & memop & aligned;
    assign bad_access = ~in_wait & memop & ~aligned;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    assign timeout_hit = in_wait & (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign mem_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
`endif

    // Request is combinational on first presentation, then replayed from hold regs.
    assign req             = rst & ((in_wait & ~timeout_hit) | issue);
    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = in_wait ? h_we_q    : DataMemWE;
    assign dmem.dmem_addr  = in_wait ? h_addr_q  : ALURes;
    assign dmem.dmem_wdata = in_wait ? h_wdata_q : Reg2DataOut;

    assign stall    = req & ~dmem.dmem_ack;
    assign bubble   = stall | timeout_hit;
    assign misalign = misalign_q;

    always_comb begin
        wb_we_d   = RegWE;
        wb_addr_d = WriteRegSrc;
        wb_data_d = wb_select(WriteDataSrc, ALURes, dmem.dmem_rdata, PCplus8);
        if (in_wait) begin
            wb_we_d   = h_regwe_q;
            wb_addr_d = h_rd_q;
            wb_data_d = wb_select(h_wsrc_q, h_addr_q, dmem.dmem_rdata, PCplus8);
        end else if (bad_access) begin
            wb_we_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE:  if (issue && !dmem.dmem_ack) state_q <= S_WAIT;
                S_WAIT:  if (timeout_hit || dmem.dmem_ack) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            if (bad_access) misalign_q <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            cnt_q <= in_wait ? cnt_q + 1'b1 : '0;
            if (timeout_hit) timeout_q <= 1'b1;
`endif
        end
    end

    // Request snapshot so WAIT never depends on upstream holding its inputs.
    always_ff @(posedge clk) begin
        if (issue) begin
            h_we_q    <= DataMemWE;
            h_addr_q  <= ALURes;
            h_wdata_q <= Reg2DataOut;
            h_rd_q    <= WriteRegSrc;
            h_regwe_q <= RegWE;
            h_wsrc_q  <= WriteDataSrc;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk         (clk),
        .rst         (rst),
        .bubble_i    (bubble),
        .we_i        (wb_we_d),
        .addr_i      (wb_addr_d),
        .data_i      (wb_data_d),
        .wb_reg_we   (wb_reg_we),
        .wb_reg_addr (wb_reg_addr),
        .wb_data     (wb_data)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected write-backs
// and memory accesses; negedge monitors pop and compare.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        DataMemWE = 1'b0;
    logic [1:0]  WriteDataSrc = 2'd0;
    logic [31:0] ALURes = 32'd0;
    logic [31:0] Reg2DataOut = 32'd0;
    logic [4:0]  WriteRegSrc = 5'd0;
    logic        RegWE = 1'b0;
    logic [31:0] PCplus8 = 32'd0;
    logic        stall, misalign, wb_reg_we;
    logic [4:0]  wb_reg_addr;
    logic [31:0] wb_data;
`ifdef MEM_TIMEOUT_EN
    logic        mem_timeout;
`endif

    mem_stage_if mif ();

    mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .DataMemWE    (DataMemWE),
        .WriteDataSrc (WriteDataSrc),
        .ALURes       (ALURes),
        .Reg2DataOut  (Reg2DataOut),
        .WriteRegSrc  (WriteRegSrc),
        .RegWE        (RegWE),
        .PCplus8      (PCplus8),
        .dmem         (mif.master),
        .stall        (stall),
        .misalign     (misalign),
        .wb_reg_we    (wb_reg_we),
        .wb_reg_addr  (wb_reg_addr),
        .wb_data      (wb_data)
`ifdef MEM_TIMEOUT_EN
        ,
        .mem_timeout  (mem_timeout)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [4:0] rd; logic [31:0] data; int due; } wb_exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
    wb_exp_t  wbq[$];
    mem_exp_t memq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] data, input int due);
        wb_exp_t e;
        e.rd = rd; e.data = data; e.due = due;
        wbq.push_back(e);
    endtask

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        mem_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata;
        memq.push_back(e);
    endtask

    // Write-back monitor: every asserted wb_reg_we must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            if (wb_reg_we) begin
                if (wbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: got write r%0d=0x%08h, expected none (cycle %0d)",
                             wb_reg_addr, wb_data, cyc);
                end else begin
                    wb_exp_t e;
                    e = wbq.pop_front();
                    chk("wb_addr", {27'd0, wb_reg_addr}, {27'd0, e.rd});
                    chk("wb_data", wb_data, e.data);
                    chk("wb_cycle", cyc, e.due);
                end
            end else if (wbq.size() > 0 && wbq[0].due < cyc) begin
                checks++; errors++;
                $display("FAIL wb_missing: got no write by cycle %0d, expected r%0d=0x%08h at %0d",
                         cyc, wbq[0].rd, wbq[0].data, wbq[0].due);
                void'(wbq.pop_front());
            end
        end
    end

    // Memory monitor: each completed handshake must match the expected access.
    always @(negedge clk) begin
        if (rst && mif.dmem_req && mif.dmem_ack) begin
            if (memq.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_unexpected: got access addr 0x%08h, expected none", mif.dmem_addr);
            end else begin
                mem_exp_t e;
                e = memq.pop_front();
                chk("mem_we", {31'd0, mif.dmem_we}, {31'd0, e.we});
                chk("mem_addr", mif.dmem_addr, e.addr);
                if (e.we) chk("mem_wdata", mif.dmem_wdata, e.wdata);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd, input logic rwe,
                         input logic [31:0] pc8);
        DataMemWE = we; WriteDataSrc = src; ALURes = alu; Reg2DataOut = wd;
        WriteRegSrc = rd; RegWE = rwe; PCplus8 = pc8;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        mif.dmem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.dmem_ack = 1'b0;
        mif.dmem_rdata = 32'd0;

        // Reset: comb outputs suppressed even with an aligned load presented.
        next(); drive(1'b0, 2'd1, 32'h100, 32'd0, 5'd1, 1'b1, 32'd0);
        @(negedge clk);
        chk("rst_req", {31'd0, mif.dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        next(); rst = 1'b1; idle();
        @(negedge clk);
        chk("rst_wb_we", {31'd0, wb_reg_we}, 32'd0);
        chk("rst_wb_addr", {27'd0, wb_reg_addr}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
`ifdef MEM_TIMEOUT_EN
        chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);
`endif

        // ALU op.
        next(); drive(1'b0, 2'd0, 32'h1234, 32'h0, 5'd5, 1'b1, 32'h0);
        push_wb(5'd5, 32'h1234, cyc + 1);
        @(negedge clk);
        chk("alu_stall", {31'd0, stall}, 32'd0);
        chk("alu_req", {31'd0, mif.dmem_req}, 32'd0);

        // Zero-wait load.
        next(); drive(1'b0, 2'd1, 32'h100, 32'h5555, 5'd7, 1'b1, 32'h0);
        mif.dmem_ack = 1'b1; mif.dmem_rdata = 32'hDEADBEEF;
        push_mem(1'b0, 32'h100, 32'h0);
        push_wb(5'd7, 32'hDEADBEEF, cyc + 1);
        @(negedge clk);
        chk("ld0_req", {31'd0, mif.dmem_req}, 32'd1);
        chk("ld0_stall", {31'd0, stall}, 32'd0);
        next(); idle();
        @(negedge clk);
        chk("ld0_req_drop", {31'd0, mif.dmem_req}, 32'd0);

        // Store with 3 wait cycles; live inputs scrambled during the wait.
        next(); drive(1'b1, 2'd0, 32'h200, 32'hCAFEF00D, 5'd0, 1'b0, 32'h0);
        push_mem(1'b1, 32'h200, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                next();
                drive(1'b0, 2'd0, 32'h999 + i, 32'h1111_1111 * i, 5'd9, 1'b1, 32'h8);
                mif.dmem_ack = (i == 3);
            end
            @(negedge clk);
            chk("st_stall", {31'd0, stall}, (i < 3) ? 32'd1 : 32'd0);
            chk("st_addr", mif.dmem_addr, 32'h200);
            chk("st_wdata", mif.dmem_wdata, 32'hCAFEF00D);
            chk("st_we", {31'd0, mif.dmem_we}, 32'd1);
        end
        next(); idle();
        @(negedge clk);
        chk("st_req_drop", {31'd0, mif.dmem_req}, 32'd0);

        // Load with 2 wait cycles; destination and source come from the hold copy.
        next(); drive(1'b0, 2'd1, 32'h300, 32'h0, 5'd12, 1'b1, 32'h0);
        push_mem(1'b0, 32'h300, 32'h0);
        for (int i = 1; i < 3; i++) begin
            next(); drive(1'b0, 2'd2, 32'h44, 32'h0, 5'd13, 1'b0, 32'h7777);
        end
        next(); mif.dmem_ack = 1'b1; mif.dmem_rdata = 32'h0BADF00D;
        push_wb(5'd12, 32'h0BADF00D, cyc + 1);
        @(negedge clk);
        chk("ldw_stall", {31'd0, stall}, 32'd0);

        // PC+8, code 3 and a write to register 0.
        next(); idle(); drive(1'b0, 2'd2, 32'h40, 32'h0, 5'd31, 1'b1, 32'h4008);
        push_wb(5'd31, 32'h4008, cyc + 1);
        next(); drive(1'b0, 2'd3, 32'h55AA, 32'h0, 5'd2, 1'b1, 32'h1);
        push_wb(5'd2, 32'h55AA, cyc + 1);
        next(); drive(1'b0, 2'd0, 32'h77, 32'h0, 5'd0, 1'b1, 32'h0);
        push_wb(5'd0, 32'h77, cyc + 1);

        // Misaligned load.
        next(); drive(1'b0, 2'd1, 32'h102, 32'h0, 5'd4, 1'b1, 32'h0);
        @(negedge clk);
        chk("mis_req", {31'd0, mif.dmem_req}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        next(); idle();
        @(negedge clk);
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_wb_we", {31'd0, wb_reg_we}, 32'd0);
        next(); idle();
        @(negedge clk);
        chk("mis_sticky", {31'd0, misalign}, 32'd1);

        // Reset in the middle of a WAIT.
        next(); drive(1'b0, 2'd1, 32'h400, 32'h0, 5'd3, 1'b1, 32'h0);
        next(); idle();
        @(negedge clk);
        chk("rw_stall", {31'd0, stall}, 32'd1);
        next(); rst = 1'b0;
        @(negedge clk);
        chk("rw_rst_req", {31'd0, mif.dmem_req}, 32'd0);
        chk("rw_rst_stall", {31'd0, stall}, 32'd0);
        next(); rst = 1'b1;
        @(negedge clk);
        chk("rw_req", {31'd0, mif.dmem_req}, 32'd0);
        chk("rw_wb_we", {31'd0, wb_reg_we}, 32'd0);
        chk("rw_wb_addr", {27'd0, wb_reg_addr}, 32'd0);
        chk("rw_wb_data", wb_data, 32'd0);
        chk("rw_misalign", {31'd0, misalign}, 32'd0);

        // Recovery after reset.
        next(); drive(1'b0, 2'd0, 32'hA5A5A5A4, 32'h0, 5'd10, 1'b1, 32'h0);
        push_wb(5'd10, 32'hA5A5A5A4, cyc + 1);

`ifdef MEM_TIMEOUT_EN
        begin
            int n;
            n = 0;
            next(); drive(1'b0, 2'd1, 32'h500, 32'h0, 5'd6, 1'b1, 32'h0);
            for (int i = 0; i < 20; i++) begin
                next(); idle();
                @(negedge clk);
                if (!mif.dmem_req) break;
                n++;
            end
            chk("to_wait_cycles", n, 32'd4);
            chk("to_stall", {31'd0, stall}, 32'd0);
            next(); idle();
            @(negedge clk);
            chk("to_flag", {31'd0, mem_timeout}, 32'd1);
            chk("to_wb_we", {31'd0, wb_reg_we}, 32'd0);
        end
`endif

        for (int i = 0; i < 3; i++) begin
            next(); idle();
        end
        @(negedge clk);
        chk("wb_queue_empty", wbq.size(), 32'd0);
        chk("mem_queue_empty", memq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage, directly downstream of the EXE/MEM pipeline register.
- Consumes the registered EXE/MEM bundle: ALU result, store data, write-back source, destination register, RegWE, DataMemWE and PC+8.
- Performs the data-memory access over a req/ack handshake with variable latency, and stalls the upstream pipeline while the access is outstanding.
- Selects the write-back data and registers the MEM/WB bundle for the WB stage.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before abort (used only with MEM_TIMEOUT_EN).
- CNT_W, 8: width of the wait counter; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- DataMemWE  in  1  store request from EXE/MEM
- WriteDataSrc  in  WDATA_SRC_LENGTH  write-back select: ALU=0, MEM=1 (load), PC8=2
- ALURes  in  32  memory byte address, or ALU result for write-back
- Reg2DataOut  in  32  store data
- WriteRegSrc  in  5  destination register
- RegWE  in  1  register write enable
- PCplus8  in  32  link value
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  byte address, word aligned
- dmem_wdata  out  32  store data
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle
- dmem_rdata  in  32  load data
- stall  out  1  hold EXE/MEM and all earlier stages this cycle
- misalign  out  1  sticky: access with ALURes[1:0] != 0 was dropped
- wb_reg_we  out  1  MEM/WB register write enable
- wb_reg_addr  out  5  MEM/WB destination register
- wb_data  out  32  MEM/WB write-back data

Behaviour:
- memop = DataMemWE | (WriteDataSrc == MEM).
- aligned = (ALURes[1:0] == 0).
- FSM states: IDLE, WAIT.
- IDLE:
  - If memop & aligned: dmem_req = 1 combinationally; dmem_we/addr/wdata are driven directly from the inputs.
  - In that same cycle, capture we/addr/wdata, WriteRegSrc, RegWE and WriteDataSrc into request-hold registers.
  - If dmem_ack in the same cycle (zero wait): no stall; stay in IDLE.
  - Otherwise: go to WAIT.
- WAIT:
  - dmem_req = 1; all memory outputs come from the hold registers. Upstream holds its inputs stable, but the stage must not depend on that.
  - On dmem_ack: return to IDLE.
- stall = dmem_req & ~dmem_ack, exactly.
- Write-back mux:
  - ALU: ALURes.
  - MEM: dmem_rdata, sampled on the ack cycle.
  - PC8: PCplus8.
  - Code 3: ALURes.
- MEM/WB register, updated every cycle:
  - Stalled cycle: bubble, wb_reg_we = 0; wb_reg_addr and wb_data hold their previous values.
  - Completing cycle: wb_reg_we = RegWE (or the hold copy when leaving WAIT); address and data per the mux.
- Latency:
  - Non-memory instruction: result visible on the MEM/WB outputs 1 cycle after presentation.
  - Memory instruction: visible 1 cycle after the ack cycle.
- Stores: write-back data irrelevant; wb_reg_we follows RegWE (normally 0).
- Misaligned memop:
  - No dmem_req, no stall.
  - wb_reg_we forced 0.
  - misalign set and held until reset.
- Reset (rst = 0 at posedge), taking effect regardless of state, including mid-WAIT:
  - state -> IDLE, wait counter cleared.
  - wb_reg_we = 0, wb_reg_addr = 0, wb_data = 0, misalign = 0.
  - The outstanding access is abandoned; dmem_req = 0 in the cycle after reset.
  - Comb outputs while rst is low: dmem_req = 0, stall = 0.
- Writes to register 0 are forwarded unchanged; register-file gating is the WB stage's responsibility.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro:
  - A CNT_W counter increments in WAIT and clears in IDLE.
  - When the counter reaches TIMEOUT_CYCLES without ack: force IDLE, drop dmem_req, emit a bubble (wb_reg_we = 0).
  - Set a sticky output port mem_timeout (1 bit, reset 0).
- Without the macro:
  - No counter and no mem_timeout port.
  - WAIT persists until ack.

Decomposition:
- Shared package/header (const.vh):
  - WDATA_SRC_LENGTH, WDATA_SRC_ALU/MEM/PC8 codes.
  - INIT_32, INIT_2.
  - MEM FSM state encodings.
- One natural sub-module: mem_wb_reg, the pure MEM/WB pipeline register (rst, bubble input).
- FSM, handshake and mux stay in mem_stage.

Test Plan:
- ALU op, WriteDataSrc=0, ALURes=0x1234, RegWE=1, WriteRegSrc=5 -> next cycle wb_reg_we=1, wb_reg_addr=5, wb_data=0x1234; stall never asserted.
- Load from 0x100, ack same cycle with rdata=0xDEADBEEF -> stall=0, dmem_req=1 for one cycle; next cycle wb_data=0xDEADBEEF.
- Store to 0x200 with data 0xCAFEF00D, ack after 3 cycles, inputs changed during the wait:
  - stall=1 for exactly 3 cycles.
  - dmem_addr/wdata stay 0x200/0xCAFEF00D throughout.
  - wb_reg_we=0 throughout.
- Load from 0x102 -> no dmem_req, no stall, misalign=1 sticky, wb_reg_we=0.
- rst low during a 2-cycle WAIT -> next cycle state IDLE, dmem_req=0, all wb_* outputs=0.
- (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4) load with no ack -> after 4 WAIT cycles: dmem_req drops, stall drops, mem_timeout=1, bubble on write-back.
